pipe_scroller: RTL

Generates the positions of the three scrolling pipes for the flappy-bird game and counts pipes passed. Sits directly upstream of the collision checker: its six pipe coordinates feed the checker's pipe inputs, and the checker's sticky game-over flag comes back here to freeze scrolling. A free-running LFSR randomises each recycled pipe's gap height. A start pulse from the button debouncer launches or relaunches a round.

---
 rtl/pipe_scroller.sv | 129 ++++++++++++
 1 files changed

// File: rtl/pipe_scroller.sv
// rtl/pipe_scroller.sv - scrolls three flappy-bird pipes, recycles them with random gap heights, counts passes
module pipe_scroller #(
  parameter int unsigned TICK_DIV   = 500000,
  parameter int unsigned STEP_PX    = 2,
  parameter int unsigned PIPE_PITCH = 480,
  parameter int unsigned X_INIT0    = 1200,
  parameter int unsigned Y_INIT     = 300,
  parameter int unsigned Y_MIN      = 150,
  parameter int unsigned BIRD_X     = 320
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_over,
  output logic [11:0] pippos_x1,
  output logic [11:0] pippos_x2,
  output logic [11:0] pippos_x3,
  output logic [11:0] pippos_y1,
  output logic [11:0] pippos_y2,
  output logic [11:0] pippos_y3,
  output logic [7:0]  score,
  output logic        running
);

  localparam int DIV_W = $clog2(TICK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [11:0] STEP     = 12'(STEP_PX);
  localparam logic [11:0] WRAP_ADD = 12'(3 * PIPE_PITCH - STEP_PX);
  localparam logic [11:0] X_I0     = 12'(X_INIT0);
  localparam logic [11:0] X_I1     = 12'(X_INIT0 + PIPE_PITCH);
  localparam logic [11:0] X_I2     = 12'(X_INIT0 + 2 * PIPE_PITCH);
  localparam logic [11:0] Y_I      = 12'(Y_INIT);
  localparam logic [11:0] Y_LO     = 12'(Y_MIN);
  localparam logic [11:0] BX       = 12'(BIRD_X);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FREEZE} state_t;

  state_t           state, state_next;
  logic             launch, tick;
  logic [DIV_W-1:0] div;
  logic [15:0]      lfsr;
  logic [11:0]      px [3];
  logic [11:0]      py [3];
  logic [11:0]      nx [3];
  logic [11:0]      ny [3];
  logic [11:0]      stepped [3];
  logic             wrap [3];
  logic             pass [3];
  logic [1:0]       pass_cnt;
  logic [8:0]       score_sum;
  logic [7:0]       score_next;

  always_comb begin
    state_next = state;
    launch     = 1'b0;
    tick       = 1'b0;
    case (state)
      S_IDLE, S_FREEZE: begin
        if (start && !is_over) begin
          state_next = S_RUN;
          launch     = 1'b1;
        end
      end
      S_RUN: begin
        // game over beats a coincident tick: the final frame is the one before it
        if (is_over) state_next = S_FREEZE;
        else if (div == DIV_LAST) tick = 1'b1;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      wrap[i]    = px[i] < STEP;
      stepped[i] = px[i] - STEP;
      nx[i]      = wrap[i] ? px[i] + WRAP_ADD : stepped[i];
      ny[i]      = wrap[i] ? Y_LO + {4'b0, lfsr[7:0]} : py[i];
      pass[i]    = !wrap[i] && (px[i] >= BX) && (stepped[i] < BX);
    end
    pass_cnt   = 2'(pass[0]) + 2'(pass[1]) + 2'(pass[2]);
    score_sum  = 9'(score) + 9'(pass_cnt);
    score_next = score_sum[8] ? 8'hFF : score_sum[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      running <= 1'b0;
      div     <= '0;
      lfsr    <= 16'hACE1;
      score   <= 8'd0;
      px[0]   <= X_I0;
      px[1]   <= X_I1;
      px[2]   <= X_I2;
      for (int i = 0; i < 3; i++) py[i] <= Y_I;
    end else begin
      state   <= state_next;
      running <= (state_next == S_RUN);
      lfsr    <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
      if (launch) begin
        div   <= '0;
        score <= 8'd0;
        px[0] <= X_I0;
        px[1] <= X_I1;
        px[2] <= X_I2;
        for (int i = 0; i < 3; i++) py[i] <= Y_I;
      end else if (state == S_RUN && !is_over) begin
        div <= tick ? '0 : div + DIV_ONE;
        if (tick) begin
          score <= score_next;
          for (int i = 0; i < 3; i++) begin
            px[i] <= nx[i];
            py[i] <= ny[i];
          end
        end
      end
    end
  end

  assign pippos_x1 = px[0];
  assign pippos_x2 = px[1];
  assign pippos_x3 = px[2];
  assign pippos_y1 = py[0];
  assign pippos_y2 = py[1];
  assign pippos_y3 = py[2];

endmodule
